// File: rtl/datatypes_p.sv
// Shared types for the k-NN datapath: coupled distance/address entries and
// the top-K sequencer state encoding.
package datatypes_p;

  localparam int unsigned DIST_BITS      = 12;
  localparam int unsigned ADDR_BITS      = 3;
  localparam int unsigned TOPK_K_DEFAULT = 4;

  // Distance in the upper bits, so an unsigned compare of the whole word
  // orders by distance first and address second.
  typedef struct packed {
    logic [DIST_BITS-1:0] d;
    logic [ADDR_BITS-1:0] addr;
  } coupled_dist_t;

  typedef enum logic [1:0] {
    StIdle,
    StInsert,
    StDrain
  } topk_state_t;

endpackage

// File: rtl/pair_sort_two.sv
// Combinational two-entry comparator: orders a pair of coupled distances.
// Smaller distance first, then smaller address; a full tie returns second
// as the smaller entry.
module pair_sort_two #(
  parameter int unsigned W = 15
) (
  input  logic [W-1:0] first,
  input  logic [W-1:0] second,
  output logic [W-1:0] smaller,
  output logic [W-1:0] larger
);

  // {d, addr} packing makes a plain unsigned compare the ranking rule.
  always_comb begin
    if (first < second) begin
      smaller = first;
      larger  = second;
    end else begin
      smaller = second;
      larger  = first;
    end
  end

endmodule

// File: rtl/topk_sched.sv
// Top-K selection sequencer. Keeps the K nearest candidates of a frame in a
// sorted list using one shared comparator per cycle, then drains the list
// in rank order.
module topk_sched
  import datatypes_p::*;
#(
  parameter int unsigned Bit = DIST_BITS,
  parameter int unsigned K   = TOPK_K_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Bit+ADDR_BITS-1:0]   in_dist,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [Bit+ADDR_BITS-1:0]   out_dist,
  output logic [$clog2(K)-1:0]       out_rank,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned W  = Bit + ADDR_BITS;
  localparam int unsigned IW = $clog2(K);
  localparam int unsigned FW = $clog2(K + 1);

  topk_state_t  state_q, state_d;
  logic [W-1:0] list_q [K];
  logic [W-1:0] list_d [K];
  logic [K-1:0] vld_q, vld_d;
  logic [W-1:0] c_q, c_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] rank_q, rank_d;
  logic         last_q, last_d;

  logic [W-1:0]  cmp_second, cmp_small, cmp_large;
  logic [FW-1:0] fill;
  logic          drain_last;
  logic          walk_done;

  assign cmp_second = list_q[i_q];

  pair_sort_two #(
    .W (W)
  ) u_pair_sort_two (
    .first   (c_q),
    .second  (cmp_second),
    .smaller (cmp_small),
    .larger  (cmp_large)
  );

  // Fill count; vld is always a contiguous prefix of the list.
  always_comb begin
    fill = '0;
    for (int k = 0; k < K; k++) begin
      fill = fill + FW'(vld_q[k]);
    end
  end

  // Handshake-facing outputs decoded from the current state.
  always_comb begin
    in_ready   = (state_q == StIdle);
    busy       = (state_q != StIdle);
    out_valid  = (state_q == StDrain);
    out_rank   = rank_q;
    drain_last = (state_q == StDrain) && (FW'(rank_q) == fill - FW'(1));
    out_last   = drain_last;
    out_dist   = out_valid ? list_q[rank_q] : '0;
  end

  // Next-state: insertion walk and rank-ordered drain.
  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    vld_d     = vld_q;
    c_d       = c_q;
    i_d       = i_q;
    rank_d    = rank_q;
    last_d    = last_q;
    walk_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          c_d     = in_dist;
          i_d     = '0;
          last_d  = in_last;
          state_d = StInsert;
        end
      end

      StInsert: begin
        if (!vld_q[i_q]) begin
          list_d[i_q] = c_q;
          vld_d[i_q]  = 1'b1;
          walk_done   = 1'b1;
        end else begin
          // Keep the nearer entry in this slot, carry the farther one down.
          list_d[i_q] = cmp_small;
          c_d         = cmp_large;
          if (i_q == IW'(K - 1)) begin
            walk_done = 1'b1;  // carried entry falls off the end
          end else begin
            i_d = i_q + 1'b1;
          end
        end
        if (walk_done) begin
          state_d = last_q ? StDrain : StIdle;
        end
      end

      StDrain: begin
        if (out_ready) begin
          if (drain_last) begin
            vld_d   = '0;
            rank_d  = '0;
            state_d = StIdle;
            for (int k = 0; k < K; k++) begin
              list_d[k] = '0;
            end
          end else begin
            rank_d = rank_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // All sequencer state, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      vld_q   <= '0;
      c_q     <= '0;
      i_q     <= '0;
      rank_q  <= '0;
      last_q  <= 1'b0;
      for (int k = 0; k < K; k++) begin
        list_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      c_q     <= c_d;
      i_q     <= i_d;
      rank_q  <= rank_d;
      last_q  <= last_d;
      for (int k = 0; k < K; k++) begin
        list_q[k] <= list_d[k];
      end
    end
  end

endmodule

// File: tb/tb_topk_sched.sv
// Bench for topk_sched: directed frames plus random frames, checked against
// a sort-and-truncate reference of each frame.
module tb_topk_sched;

  localparam int unsigned Bit = 12;
  localparam int unsigned K   = 4;
  localparam int unsigned W   = Bit + 3;
  localparam int unsigned RW  = $clog2(K);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_dist;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_dist;
  logic [RW-1:0] out_rank;
  logic          out_last;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Candidates of the frame in progress, in arrival order.
  logic [W-1:0] frame[$];

  topk_sched #(
    .Bit (Bit),
    .K   (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dist   (in_dist),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dist  (out_dist),
    .out_rank  (out_rank),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] cd(input int d, input int a);
    logic [Bit-1:0] dv;
    logic [2:0]     av;
    dv = Bit'(d);
    av = 3'(a);
    return {dv, av};
  endfunction

  // Offer one candidate at a negedge while idle, then count INSERT cycles.
  task automatic send(input int d, input int a, input bit last);
    int exp_cyc;
    int cnt;
    exp_cyc = (frame.size() < K) ? frame.size() + 1 : K;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_dist  = cd(d, a);
    in_last  = last;
    @(negedge clk);
    frame.push_back(cd(d, a));
    cnt = 0;
    while (!in_ready && !out_valid && cnt < 40) begin
      // Junk offered while busy must be ignored.
      in_valid = 1'($urandom);
      in_dist  = W'($urandom);
      in_last  = 1'($urandom);
      cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("insert_cycles", 32'(cnt), 32'(exp_cyc));
  endtask

  // Drain the frame; hold_fixed < 0 picks random backpressure per rank.
  task automatic drain(input int hold_fixed);
    logic [W-1:0] exp[$];
    int n;
    int hold;
    exp = frame;
    exp.sort();
    while (exp.size() > K) void'(exp.pop_back());
    n = exp.size();
    check("drain_start", 32'(out_valid), 32'd1);
    for (int r = 0; r < n; r++) begin
      hold = (hold_fixed >= 0) ? hold_fixed : int'($urandom_range(0, 2));
      for (int h = 0; h < hold; h++) begin
        out_ready = 1'b0;
        @(negedge clk);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_dist", 32'(out_dist), 32'(exp[r]));
        check("hold_rank", 32'(out_rank), 32'(r));
      end
      out_ready = 1'b1;
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_dist", 32'(out_dist), 32'(exp[r]));
      check("out_rank", 32'(out_rank), 32'(r));
      check("out_last", 32'(out_last), 32'(r == n - 1));
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    frame.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_dist"}, 32'(out_dist), 32'd0);
    check({tag, "_out_rank"}, 32'(out_rank), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_dist   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic sort
    send(50, 0, 0);
    send(20, 1, 0);
    send(70, 2, 0);
    send(10, 3, 1);
    drain(-1);

    // Overflow: the two farthest fall off
    send(60, 0, 0);
    send(50, 1, 0);
    send(40, 2, 0);
    send(30, 3, 0);
    send(20, 4, 0);
    send(10, 5, 1);
    drain(0);

    // Tie-break on address
    send(25, 5, 0);
    send(25, 2, 1);
    drain(0);

    // Partial frame
    send(9, 1, 0);
    send(3, 4, 1);
    drain(0);

    // Backpressure: three stalled cycles per rank
    send(100, 7, 0);
    send(4, 6, 0);
    send(55, 0, 0);
    send(4, 1, 1);
    drain(3);

    // Reset during the third candidate's walk
    send(5, 1, 0);
    send(7, 2, 0);
    in_valid = 1'b1;
    in_dist  = cd(6, 3);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    frame.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(30, 3, 0);
    send(8, 0, 0);
    send(30, 1, 1);
    drain(-1);

    // Random frames, including ties and overflow
    for (int f = 0; f < 30; f++) begin
      n = int'($urandom_range(1, 7));
      for (int c = 0; c < n; c++) begin
        send(int'($urandom_range(0, 40)), int'($urandom_range(0, 7)), c == n - 1);
      end
      drain(-1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/topk_sched.md
# topk_sched

Sequencing controller for the k-NN top-K selection stage. It accepts a stream of `coupled_dist_t` candidates (distance `d`, 3-bit `addr`) per query frame. It keeps a sorted list of the K nearest entries by running one shared combinational `pair_sort_two` comparator once per cycle, in an insertion walk. At frame end it drains the list in rank order to the voting stage.

## Interface
Parameters:
- `Bit`, 12: distance width; `coupled_dist_t` is `Bit+3` bits.
- `K`, 4: list depth, 2..8.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  candidate valid.
- `in_ready`  out  1  candidate accepted when `in_valid && in_ready`.
- `in_dist`  in  Bit+3  candidate (`datatypes_p::coupled_dist_t`).
- `in_last`  in  1  candidate is the last of the frame.
- `out_valid`  out  1  ranked result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_dist`  out  Bit+3  result entry.
- `out_rank`  out  $clog2(K)  rank of `out_dist`; 0 = nearest.
- `out_last`  out  1  final result of the frame.
- `busy`  out  1  high in INSERT or DRAIN.

## Operation
- Storage:
  - `list[0..K-1]` of `coupled_dist_t` with per-slot `vld` bits.
  - Candidate register `c`, walk index `i`, `last_q` flag.
  - Fill count = number of set `vld` bits.
- Ordering is the comparator rule. Smaller `d` ranks first. On equal `d`, smaller `addr` ranks first. Equal `d` and equal `addr` returns `second`.
- FSM states are IDLE, INSERT and DRAIN.
- IDLE:
  - `in_ready`=1.
  - On accept: `c`<=`in_dist`, `i`<=0, `last_q`<=`in_last`, go to INSERT.
- INSERT, one comparison per cycle (`first`=`c`, `second`=`list[i]`):
  - If `vld[i]`=0: `list[i]`<=`c`, `vld[i]`<=1; the walk is done.
  - Else: `list[i]`<=smaller, `c`<=larger.
  - If `i`=K-1, the walk is done and larger is discarded. Otherwise `i`<=`i`+1.
  - When the walk is done, go to DRAIN if `last_q`, else to IDLE.
- DRAIN:
  - `out_valid`=1, `out_dist`=`list[out_rank]`, `out_last`=(`out_rank`=fill-1).
  - On handshake, `out_rank` increments.
  - On the handshake with `out_last`: clear all `vld`, zero `list`, set `out_rank`<=0, go to IDLE.
- Full list: an out-of-list candidate falls off the end after K compares. The list never exceeds K entries.
- `in_valid` while not in IDLE is ignored; `in_ready`=0.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE).
  - `out_valid`=0, `out_dist`=0, `out_rank`=0, `out_last`=0, `busy`=0.
  - All `vld` and `list` entries 0.
- Insert latency: accept at edge T; INSERT occupies min(fill+1, K) cycles; `in_ready` returns in the cycle after the final INSERT edge.
- Worst-case throughput is one candidate per K+1 cycles.
- DRAIN:
  - `out_valid` rises the cycle after the final insert edge of the `in_last` candidate.
  - Fill results, one per cycle when `out_ready`=1.
- Backpressure: with `out_ready`=0, `out_dist`, `out_rank` and `out_last` hold stable.
- Reset asserted at any time, including mid-INSERT or mid-DRAIN:
  - Immediately returns every register to its reset value.
  - The partial frame is lost, and no result is emitted for it.

## Structure
- `datatypes_p` provides `coupled_dist_t`.
- Add `topk_state_t` (IDLE/INSERT/DRAIN) to `datatypes_p`.
- Add a package constant `TOPK_K_DEFAULT`=4 to `datatypes_p`.
- Sub-module: one instance of `pair_sort_two`, the existing combinational comparator. No other comparator logic in this block.
- Sequential state uses a single `always_ff` on `posedge clk or negedge rst`.

## Test plan
- Basic sort (K=4):
  - Stimulus: `in_dist` (d,addr) = (50,0),(20,1),(70,2),(10,3), `in_last` on the 4th.
  - Response: ranks 0..3 = (10,3),(20,1),(50,0),(70,2); `out_last` only at rank 3.
  - The 4th insert takes 4 INSERT cycles.
- Overflow:
  - Stimulus: six candidates d=60,50,40,30,20,10 (addr 0..5).
  - Response: output d=10,20,30,40; d=60 and d=50 are dropped.
- Tie-break:
  - Stimulus: (25,5) then (25,2), last.
  - Response: rank0=(25,2), rank1=(25,5).
- Partial frame:
  - Stimulus: two candidates (9,1),(3,4), last.
  - Response: exactly two outputs, (3,4) then (9,1); `out_last` at rank 1; then IDLE with `in_ready`=1.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 3 cycles in DRAIN.
  - Response: `out_valid`=1 with `out_dist`/`out_rank` unchanged, no rank skipped.
- Reset mid-INSERT:
  - Stimulus: pull `rst` low during the 3rd candidate's walk.
  - Response: all outputs reach reset values asynchronously; a subsequent frame sorts correctly with no stale entries.
